// File: rtl/mult_seq_if.sv
// Handshake bundle for the sequential multiplier.
// The operand side (in_valid/in_ready/a/b/is_signed) and the product side
// (out_valid/out_ready/p) are carried together in this interface.
interface mult_seq_if #(
    parameter int WIDTH = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   is_signed;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     p;

    // Producer/consumer side: drives operands, takes the product
    modport master (
        output in_valid, a, b, is_signed, out_ready,
        input  in_ready, out_valid, p
    );

    // Multiplier side
    modport slave (
        input  in_valid, a, b, is_signed, out_ready,
        output in_ready, out_valid, p
    );
endinterface

// File: rtl/mult_seq.sv
// Sequential radix-2 shift-add multiplier with fixed WIDTH-cycle latency.
// Signed operands are converted to magnitudes at capture and the product is
// negated at the end, so the core loop is always unsigned.
module mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    mult_seq_if.slave   bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // WIDTH >= 2, so the counter is at least one bit and WIDTH-1 always fits
    localparam int CW = $clog2(WIDTH);

    logic [1:0]             state;
    logic [CW-1:0]          count;
    logic [WIDTH-1:0]       mcand;
    logic [WIDTH-1:0]       mplier;
    logic                   neg;
    logic [2*WIDTH:0]       acc;
    logic [2*WIDTH-1:0]     p_reg;

    logic [WIDTH-1:0]       mag_a;
    logic [WIDTH-1:0]       mag_b;
    logic [WIDTH:0]         sum;
    logic [2*WIDTH:0]       acc_next;
    logic [2*WIDTH-1:0]     product;
    logic [2*WIDTH-1:0]     result;
    logic                   last;

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.p         = p_reg;

    // Magnitudes at capture; negating the most negative value wraps to
    // 2^(WIDTH-1), which is exactly its magnitude as an unsigned number.
    assign mag_a = (bus.is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign mag_b = (bus.is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    // One shift-add step: add into the upper WIDTH+1 bits, then shift right
    assign sum      = acc[2*WIDTH:WIDTH] + (mplier[0] ? {1'b0, mcand} : '0);
    assign acc_next = {1'b0, sum, acc[WIDTH-1:1]};
    assign product  = acc_next[2*WIDTH-1:0];

    // Two's-complement negation of a zero magnitude is zero, so a sign of 1
    // with a zero product can never produce a "negative zero".
    assign result = neg ? -product : product;
    assign last   = (count == CW'(WIDTH - 1));

    // Control FSM: IDLE accepts, RUN iterates WIDTH times, DONE holds until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        state <= RUN;
                        count <= '0;
                    end
                end
                RUN: begin
                    count <= count + 1'b1;
                    if (last) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath: operand capture, accumulate/shift, and product load on the last step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            neg    <= 1'b0;
            acc    <= '0;
            p_reg  <= '0;
        end else begin
            if (state == IDLE && bus.in_valid) begin
                mcand  <= mag_a;
                mplier <= mag_b;
                neg    <= bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                acc    <= '0;
            end else if (state == RUN) begin
                acc    <= acc_next;
                mplier <= mplier >> 1;
                if (last) begin
                    p_reg <= result;
                end
            end
        end
    end
endmodule

// File: tb/tb_mult_seq.sv
// Testbench for mult_seq: directed WIDTH=8 vectors plus an exhaustive
// WIDTH=4 run with random consumer backpressure.
module tb_mult_seq;
    logic clk;
    logic rst_n;

    int n_cmp = 0;
    int n_err = 0;

    mult_seq_if #(.WIDTH(8)) bus8();
    mult_seq_if #(.WIDTH(4)) bus4();

    mult_seq #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8.slave)
    );

    mult_seq #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for out_valid on the 8-bit instance, scribbling on the inputs
    // (with in_valid high) while the operation is in flight.
    task automatic wait_out8(output int lat, output bit busy_ok);
        lat     = 0;
        busy_ok = 1'b1;
        while (lat < 40) begin
            tick();
            lat++;
            if (bus8.out_valid) break;
            if (bus8.in_ready) busy_ok = 1'b0;
            bus8.in_valid  = 1'b1;
            bus8.a         = 8'($urandom);
            bus8.b         = 8'($urandom);
            bus8.is_signed = 1'($urandom);
        end
    endtask

    // One full transaction on the 8-bit instance with out_ready held high
    task automatic run8(input string tag, input logic [7:0] aa, input logic [7:0] bb,
                        input logic s, input logic [15:0] exp);
        int lat;
        bit busy_ok;
        bus8.a = aa; bus8.b = bb; bus8.is_signed = s;
        bus8.in_valid = 1'b1; bus8.out_ready = 1'b1;
        check({tag, "_rdy"}, 32'(bus8.in_ready), 32'd1);
        tick();
        bus8.in_valid = 1'b0;
        wait_out8(lat, busy_ok);
        bus8.in_valid = 1'b0;
        check({tag, "_lat"}, 32'(lat), 32'd8);
        check({tag, "_busy"}, 32'(busy_ok), 32'd1);
        check({tag, "_p"}, 32'(bus8.p), 32'(exp));
        tick();
        check({tag, "_ov_1cyc"}, 32'(bus8.out_valid), 32'd0);
        check({tag, "_idle"}, 32'(bus8.in_ready), 32'd1);
    endtask

    logic [7:0] q4[$];
    bit         prod_done;

    initial begin
        int lat;
        bit busy_ok;

        rst_n = 1'b0;
        bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.is_signed = 1'b0; bus8.out_ready = 1'b0;
        bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.is_signed = 1'b0; bus4.out_ready = 1'b0;
        #1;
        check("rst_in_ready", 32'(bus8.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus8.out_valid), 32'd0);
        check("rst_p", 32'(bus8.p), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        run8("u255x255", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
        run8("s_m128sq", 8'h80, 8'h80, 1'b1, 16'h4000);
        run8("s_m3x5",   8'hFD, 8'h05, 1'b1, 16'hFFF1);
        run8("u_fdx5",   8'hFD, 8'h05, 1'b0, 16'h04F1);
        run8("s_0xm7",   8'h00, 8'hF9, 1'b1, 16'h0000);
        run8("s_m128x1", 8'h80, 8'h01, 1'b1, 16'hFF80);

        // Backpressure: 12 x 10 with the consumer stalled for 5 cycles
        bus8.a = 8'd12; bus8.b = 8'd10; bus8.is_signed = 1'b0;
        bus8.in_valid = 1'b1; bus8.out_ready = 1'b0;
        tick();
        bus8.in_valid = 1'b0;
        wait_out8(lat, busy_ok);
        check("bp_lat", 32'(lat), 32'd8);
        check("bp_p0", 32'(bus8.p), 32'h78);
        for (int i = 0; i < 5; i++) begin
            bus8.in_valid = i[0];
            bus8.a = 8'($urandom); bus8.b = 8'($urandom);
            tick();
            check("bp_hold_ov", 32'(bus8.out_valid), 32'd1);
            check("bp_hold_p", 32'(bus8.p), 32'h78);
        end
        bus8.in_valid = 1'b0;
        bus8.out_ready = 1'b1;
        tick();
        check("bp_rel_idle", 32'(bus8.in_ready), 32'd1);
        check("bp_rel_ov", 32'(bus8.out_valid), 32'd0);
        check("bp_p_kept", 32'(bus8.p), 32'h78);

        // Reset in the middle of RUN
        bus8.a = 8'd200; bus8.b = 8'd3; bus8.is_signed = 1'b0; bus8.in_valid = 1'b1;
        tick();
        bus8.in_valid = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        check("mrst_ov", 32'(bus8.out_valid), 32'd0);
        check("mrst_p", 32'(bus8.p), 32'd0);
        check("mrst_rdy", 32'(bus8.in_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        run8("post_rst_7x9", 8'd7, 8'd9, 1'b0, 16'h003F);

        // Exhaustive WIDTH=4, both modes, back-to-back with random out_ready
        prod_done = 1'b0;
        fork
            begin : producer
                for (int s = 0; s < 2; s++) begin
                    for (int ia = 0; ia < 16; ia++) begin
                        for (int ib = 0; ib < 16; ib++) begin
                            int sa, sb, wait_cyc;
                            sa = (s == 1 && ia > 7) ? ia - 16 : ia;
                            sb = (s == 1 && ib > 7) ? ib - 16 : ib;
                            bus4.a = 4'(ia); bus4.b = 4'(ib); bus4.is_signed = 1'(s);
                            bus4.in_valid = 1'b1;
                            wait_cyc = 0;
                            while (!bus4.in_ready && wait_cyc < 200) begin
                                tick();
                                wait_cyc++;
                            end
                            q4.push_back(8'(sa * sb));
                            tick();
                        end
                    end
                end
                bus4.in_valid = 1'b0;
                prod_done = 1'b1;
            end
            begin : consumer
                int got_n, cyc;
                got_n = 0;
                cyc = 0;
                while (got_n < 512 && cyc < 40000) begin
                    bus4.out_ready = 1'($urandom);
                    if (bus4.out_valid && bus4.out_ready) begin
                        if (q4.size() == 0) begin
                            check("w4_extra_out", 32'd1, 32'd0);
                        end else begin
                            check("w4_p", 32'(bus4.p), 32'(q4.pop_front()));
                        end
                        got_n++;
                    end
                    tick();
                    cyc++;
                end
                check("w4_out_count", 32'(got_n), 32'd512);
            end
        join
        check("w4_all_sent", 32'(prod_done), 32'd1);
        check("w4_queue_empty", 32'(q4.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mult_seq.md
MULT_SEQ -- requirements
Module: mult_seq

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-004 Port: in_valid  input  1  operand pair and mode presented.
REQ-005 Port: in_ready  output  1  block can accept a new operand pair.
REQ-006 Port: a  input  WIDTH  multiplicand.
REQ-007 Port: b  input  WIDTH  multiplier.
REQ-008 Port: is_signed  input  1  1 = a and b two's complement; 0 = unsigned.
REQ-009 Port: out_valid  output  1  product p valid.
REQ-010 Port: out_ready  input  1  consumer takes p.
REQ-011 Port: p  output  2*WIDTH  product.

Function
REQ-012 FSM states SHALL be IDLE, RUN, DONE; reset state IDLE.
REQ-013 in_ready SHALL be 1 only in IDLE; 0 in RUN and DONE.
REQ-014 Acceptance SHALL occur on a rising edge with in_valid=1 and in_ready=1; a, b, is_signed are captured and the FSM moves to RUN with iteration count 0.
REQ-015 In signed mode, capture SHALL store |a| and |b| as WIDTH-bit unsigned magnitudes plus result sign = a[WIDTH-1] XOR b[WIDTH-1]; the most negative value (e.g. -128 for WIDTH=8) SHALL map to magnitude 2^(WIDTH-1) without overflow.
REQ-016 In unsigned mode, magnitudes SHALL equal a and b and result sign SHALL be 0.
REQ-017 RUN SHALL perform radix-2 shift-add: each cycle, if current multiplier LSB = 1, add multiplicand magnitude to the upper WIDTH+1 bits of a 2*WIDTH+1-bit accumulator, then shift accumulator and multiplier right by one.
REQ-018 RUN SHALL last exactly WIDTH cycles regardless of operand values, including zero operands (fixed latency).
REQ-019 On the final RUN edge, p SHALL be loaded with the 2*WIDTH-bit magnitude product, two's-complement negated if result sign = 1, and the FSM SHALL enter DONE.
REQ-020 out_valid SHALL be 1 exactly in DONE; the first cycle with out_valid=1 SHALL begin WIDTH clock edges after the accepting edge.
REQ-021 In DONE, p SHALL stay stable until a rising edge with out_ready=1, after which the FSM SHALL return to IDLE; out_ready=0 SHALL hold DONE indefinitely.
REQ-022 in_valid and input changes during RUN or DONE SHALL be ignored and SHALL NOT corrupt the operation in progress.
REQ-023 Negative zero SHALL NOT occur: a zero product with sign 1 SHALL yield p = 0.
REQ-024 p SHALL hold its last value in IDLE after a completed transaction; it changes only on the final RUN edge or on reset.
REQ-025 Throughput: one product per WIDTH+2 cycles minimum (accept edge, WIDTH RUN edges, one DONE handshake edge).

Reset
REQ-026 rst_n low SHALL asynchronously force state IDLE, in_ready=1, out_valid=0, p=0, and clear accumulator, counter, operand, and sign registers.
REQ-027 Reset asserted during RUN or DONE SHALL abort the operation with no output; the first rising edge after release with in_valid=1 SHALL accept a new pair normally.
REQ-028 No output SHALL show X after reset release, whatever the input values.

Verification (WIDTH=8 unless stated)
REQ-029 Unsigned 255 x 255, out_ready=1 -> p=0xFE01; out_valid first high 8 edges after acceptance, for exactly one cycle; in_ready low for the whole transaction.
REQ-030 Signed -128 x -128 -> p=0x4000; signed -3 (0xFD) x 5 -> p=0xFFF1; unsigned 0xFD x 5 -> p=0x04F1; signed 0 x -7 -> p=0x0000.
REQ-031 Backpressure: product 12 x 10 with out_ready held 0 for 5 cycles -> out_valid and p=0x0078 stable for all 5 cycles; in_valid pulses during that time not accepted; IDLE one edge after out_ready=1.
REQ-032 Reset mid-RUN: assert rst_n=0 at RUN iteration 3 -> out_valid=0, p=0, in_ready=1 at once; after release, 7 x 9 gives p=0x003F with full 8-cycle latency.
REQ-033 WIDTH=4, exhaustive: all 256 (a,b) pairs in both modes, back-to-back, random out_ready -> every p matches a golden model (unsigned 0..225, signed -56..64), one output per accepted input, in order.
